// File: rtl/draw_layer_arbiter.sv
// rtl/draw_layer_arbiter.sv - per-pixel layer compositor with per-frame overlap reporting
module draw_layer_arbiter #(
  parameter int                    NUM_LAYERS  = 8,
  parameter logic [NUM_LAYERS-1:0] HAZARD_MASK = 8'b0000_0110,
  parameter logic [NUM_LAYERS-1:0] GOAL_MASK   = 8'b1000_0000,
  parameter logic [7:0]            BG_RGB      = 8'b000_000_00,
  localparam int                   IDX_W       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    startOfFrame,
  input  logic [NUM_LAYERS-1:0]   layer_req,
  input  logic [8*NUM_LAYERS-1:0] layer_rgb,
  output logic [7:0]              mVGA_RGB,
  output logic                    drawing_request,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    collision,
  output logic                    goal_reached,
  output logic                    frame_valid
);

  // The frog (layer 0) can never overlap itself, so bit 0 is stripped from both masks.
  localparam logic [NUM_LAYERS-1:0] HZ_EFF = {HAZARD_MASK[NUM_LAYERS-1:1], 1'b0};
  localparam logic [NUM_LAYERS-1:0] GL_EFF = {GOAL_MASK[NUM_LAYERS-1:1], 1'b0};

  typedef enum logic {WAIT_SOF, RUN} state_t;

  state_t           state, state_nxt;
  logic             hz_acc, gl_acc, hz_acc_nxt, gl_acc_nxt;
  logic             coll_nxt, goal_nxt;
  logic             hz, gl;
  logic [IDX_W-1:0] win_idx;
  logic [7:0]       win_rgb;
  logic             any_req;

  // Fixed-priority pick: scan from the top so the lowest requesting index lands last.
  always_comb begin
    win_idx = '0;
    win_rgb = BG_RGB;
    any_req = |layer_req;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_req[i]) begin
        win_idx = IDX_W'(i);
        win_rgb = layer_rgb[8*i +: 8];
      end
    end
  end

  // Overlap of the frog with hazard/goal layers on this pixel.
  always_comb begin
    hz = layer_req[0] & |(layer_req & HZ_EFF);
    gl = layer_req[0] & |(layer_req & GL_EFF);
  end

  // Registered composite outputs, independent of the frame FSM state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      mVGA_RGB        <= BG_RGB;
      drawing_request <= 1'b0;
      grant_idx       <= '0;
    end else begin
      mVGA_RGB        <= win_rgb;
      drawing_request <= any_req;
      grant_idx       <= win_idx;
    end
  end

  // Frame FSM next-state: accumulate overlaps, and report the finished frame on each SOF.
  always_comb begin
    state_nxt   = state;
    hz_acc_nxt  = 1'b0;
    gl_acc_nxt  = 1'b0;
    coll_nxt    = 1'b0;
    goal_nxt    = 1'b0;
    frame_valid = 1'b0;
    case (state)
      WAIT_SOF: begin
        if (startOfFrame) begin
          state_nxt  = RUN;
          hz_acc_nxt = hz;
          gl_acc_nxt = gl;
        end
      end
      RUN: begin
        frame_valid = 1'b1;
        if (startOfFrame) begin
          coll_nxt   = hz_acc;
          goal_nxt   = gl_acc;
          hz_acc_nxt = hz;
          gl_acc_nxt = gl;
        end else begin
          hz_acc_nxt = hz_acc | hz;
          gl_acc_nxt = gl_acc | gl;
        end
      end
      default: state_nxt = WAIT_SOF;
    endcase
  end

  // Frame FSM state, accumulators and report pulses; reset discards any pending report.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= WAIT_SOF;
      hz_acc       <= 1'b0;
      gl_acc       <= 1'b0;
      collision    <= 1'b0;
      goal_reached <= 1'b0;
    end else begin
      state        <= state_nxt;
      hz_acc       <= hz_acc_nxt;
      gl_acc       <= gl_acc_nxt;
      collision    <= coll_nxt;
      goal_reached <= goal_nxt;
    end
  end

endmodule

// File: tb/tb_draw_layer_arbiter.sv
// tb/tb_draw_layer_arbiter.sv - directed self-checking bench for draw_layer_arbiter
module tb_draw_layer_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        startOfFrame;
  logic [7:0]  layer_req;
  logic [63:0] layer_rgb;
  logic [7:0]  mVGA_RGB;
  logic        drawing_request;
  logic [2:0]  grant_idx;
  logic        collision;
  logic        goal_reached;
  logic        frame_valid;

  int errors = 0;
  int checks = 0;
  int coll_pulses = 0;
  int goal_pulses = 0;

  draw_layer_arbiter dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .startOfFrame    (startOfFrame),
    .layer_req       (layer_req),
    .layer_rgb       (layer_rgb),
    .mVGA_RGB        (mVGA_RGB),
    .drawing_request (drawing_request),
    .grant_idx       (grant_idx),
    .collision       (collision),
    .goal_reached    (goal_reached),
    .frame_valid     (frame_valid)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (collision === 1'b1) coll_pulses++;
    if (goal_reached === 1'b1) goal_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic sof_step();
    startOfFrame = 1'b1;
    step(1);
    startOfFrame = 1'b0;
  endtask

  task automatic chk_pulses(input string tag, input logic c, input logic g);
    chk({tag, "_coll"}, 32'(collision), 32'(c));
    chk({tag, "_goal"}, 32'(goal_reached), 32'(g));
  endtask

  initial begin
    RESET        = 1'b1;
    startOfFrame = 1'b0;
    layer_req    = 8'h00;
    layer_rgb    = {8'h44, 8'h66, 8'h55, 8'h33, 8'h03, 8'h1C, 8'hE0, 8'hFF};
    step(2);
    chk("rst_rgb", 32'(mVGA_RGB), 32'h00);
    chk("rst_dreq", 32'(drawing_request), 32'h0);
    chk("rst_grant", 32'(grant_idx), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk_pulses("rst", 1'b0, 1'b0);
    RESET = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("idle_rgb", 32'(mVGA_RGB), 32'h00);
      chk("idle_dreq", 32'(drawing_request), 32'h0);
      chk("idle_fv", 32'(frame_valid), 32'h0);
    end
    chk("idle_coll_cnt", 32'(coll_pulses), 32'd0);
    chk("idle_goal_cnt", 32'(goal_pulses), 32'd0);

    layer_req = 8'b1000_0110;
    step(1);
    chk("prio_rgb", 32'(mVGA_RGB), 32'hE0);
    chk("prio_grant", 32'(grant_idx), 32'd1);
    chk("prio_dreq", 32'(drawing_request), 32'h1);
    layer_req = 8'b1000_0000;
    step(1);
    chk("l7_rgb", 32'(mVGA_RGB), 32'h44);
    chk("l7_grant", 32'(grant_idx), 32'd7);

    layer_req = 8'b1000_0011;
    step(1);
    chk("frog_rgb", 32'(mVGA_RGB), 32'hFF);
    chk("frog_grant", 32'(grant_idx), 32'd0);
    chk("frog_dreq", 32'(drawing_request), 32'h1);
    layer_req = 8'h00;
    step(1);
    chk("bg_rgb", 32'(mVGA_RGB), 32'h00);
    chk("bg_grant", 32'(grant_idx), 32'd0);
    chk("bg_dreq", 32'(drawing_request), 32'h0);
    chk("pre_sof_fv", 32'(frame_valid), 32'h0);

    sof_step();
    chk("sof1_fv", 32'(frame_valid), 32'h1);
    chk_pulses("sof1", 1'b0, 1'b0);
    step(3);
    layer_req = 8'b1000_0011;
    step(1);
    layer_req = 8'h00;
    step(5);
    chk_pulses("pre_sof2", 1'b0, 1'b0);
    sof_step();
    chk_pulses("sof2", 1'b1, 1'b1);
    step(1);
    chk_pulses("sof2_after", 1'b0, 1'b0);

    step(49);
    layer_req = 8'b0000_0101;
    step(1);
    layer_req = 8'h00;
    step(49);
    sof_step();
    chk_pulses("sof3", 1'b1, 1'b0);
    step(1);
    chk_pulses("sof3_after", 1'b0, 1'b0);

    step(20);
    sof_step();
    chk_pulses("sof4_quiet", 1'b0, 1'b0);
    step(5);

    layer_req = 8'b0000_0011;
    sof_step();
    layer_req = 8'h00;
    chk_pulses("sof5_same_cycle", 1'b0, 1'b0);
    step(10);
    sof_step();
    chk_pulses("sof6", 1'b1, 1'b0);
    step(3);

    layer_req = 8'b0000_0101;
    sof_step();
    layer_req = 8'h00;
    chk_pulses("sof7_b2b", 1'b0, 1'b0);
    sof_step();
    chk_pulses("sof8_b2b", 1'b1, 1'b0);
    step(1);
    chk_pulses("sof8_after", 1'b0, 1'b0);
    step(3);

    sof_step();
    chk_pulses("sof9", 1'b0, 1'b0);
    layer_req = 8'b0000_0011;
    step(1);
    layer_req = 8'h00;
    RESET = 1'b1;
    step(1);
    RESET = 1'b0;
    chk("mid_rst_fv", 32'(frame_valid), 32'h0);
    chk_pulses("mid_rst", 1'b0, 1'b0);
    step(4);
    chk("pre_sof10_fv", 32'(frame_valid), 32'h0);
    sof_step();
    chk("sof10_fv", 32'(frame_valid), 32'h1);
    chk_pulses("sof10", 1'b0, 1'b0);
    step(1);
    chk_pulses("sof10_after", 1'b0, 1'b0);

    layer_req = 8'b1000_0011;
    step(1);
    layer_req = 8'h00;
    RESET = 1'b1;
    startOfFrame = 1'b1;
    step(1);
    RESET = 1'b0;
    startOfFrame = 1'b0;
    chk("rst_sof_fv", 32'(frame_valid), 32'h0);
    chk_pulses("rst_sof", 1'b0, 1'b0);
    step(2);
    chk_pulses("rst_sof_after", 1'b0, 1'b0);

    chk("total_coll_pulses", 32'(coll_pulses), 32'd4);
    chk("total_goal_pulses", 32'(goal_pulses), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/draw_layer_arbiter.md
Name: draw_layer_arbiter

Overview:
- Per-pixel compositor and collision scheduler for the VGA pipeline.
- Collects drawing_request/RGB pairs from up to NUM_LAYERS drawers (frog, cars, logs, river, end bank, ...).
- Grants the pixel to the highest-priority requesting layer and drives the registered VGA colour.
- Accumulates per-frame overlap events (frog vs. hazard layers, frog vs. goal layers) and reports them once per frame to the game logic.

Parameters:
- NUM_LAYERS, 8, number of drawer inputs; layer 0 is highest priority and is the frog layer.
- HAZARD_MASK, 8'b0000_0110, layers whose overlap with layer 0 counts as a collision.
- GOAL_MASK, 8'b1000_0000, layers whose overlap with layer 0 counts as reaching the goal.
- BG_RGB, 8'b000_000_00, colour driven when no layer requests (rrrgggbb).

Ports:
- CLK  in  1  pixel clock
- RESET  in  1  synchronous, active-high reset
- startOfFrame  in  1  single-cycle pulse on the first pixel of each frame
- layer_req  in  NUM_LAYERS  drawing_request from each layer; bit i = layer i
- layer_rgb  in  8*NUM_LAYERS  colour of layer i on bits [8i+7:8i]
- mVGA_RGB  out  8  composited pixel colour
- drawing_request  out  1  any layer requested this pixel
- grant_idx  out  clog2(NUM_LAYERS)  index of the winning layer; 0 when no request
- collision  out  1  one-cycle pulse: the previous frame contained a frog/hazard overlap
- goal_reached  out  1  one-cycle pulse: the previous frame contained a frog/goal overlap
- frame_valid  out  1  high once the first startOfFrame has been seen since reset

Behaviour:
- Reset: all outputs are 0, except mVGA_RGB = BG_RGB. Accumulators are cleared and the FSM enters WAIT_SOF. RESET is sampled only on the CLK edge and overrides every other input.
- Arbitration: fixed priority, lowest index wins.
  - mVGA_RGB, drawing_request and grant_idx are registered with 1-cycle latency from layer_req/layer_rgb.
  - The colour outputs follow arbitration in both FSM states.
  - With no request: mVGA_RGB = BG_RGB, drawing_request = 0, grant_idx = 0.
- Overlap detect, evaluated each cycle:
  - hz = layer_req[0] & |(layer_req & HAZARD_MASK)
  - gl = layer_req[0] & |(layer_req & GOAL_MASK)
  - Bit 0 of either mask is ignored, so the frog never overlaps itself.
- Accumulators hz_acc and gl_acc are sticky ORs of hz and gl over the current frame.
- FSM:
  - WAIT_SOF: accumulators are held at 0; collision and goal_reached stay 0; frame_valid = 0. On startOfFrame, go to RUN and load hz_acc <= hz, gl_acc <= gl.
  - RUN: frame_valid = 1.
    - On a cycle without startOfFrame: hz_acc |= hz, gl_acc |= gl.
    - On a cycle with startOfFrame: collision <= hz_acc and goal_reached <= gl_acc, both visible on the next cycle for exactly one cycle. Then hz_acc <= hz and gl_acc <= gl; the pixel on the startOfFrame cycle belongs to the new frame.
- Partial frame after reset is never reported; the first report follows the second startOfFrame.
- Back-to-back startOfFrame pulses in consecutive cycles are legal. Each produces a report of the one-cycle "frame" preceding it.
- A hazard and a goal overlap in the same frame are both reported in the same cycle.
- RESET asserted mid-frame discards the accumulators. No pulse is emitted, including when RESET coincides with startOfFrame.

Test Plan:
- Reset, then layer_req = 0 for 10 cycles:
  - mVGA_RGB = 8'h00, drawing_request = 0, frame_valid = 0
  - collision/goal_reached never pulse.
- Priority: layer_req = 8'b1000_0110, layer_rgb layer1 = 8'hE0, layer2 = 8'h1C, layer7 = 8'h44 → next cycle mVGA_RGB = 8'hE0, grant_idx = 1.
  - Then layer_req = 8'b1000_0000 → mVGA_RGB = 8'h44, grant_idx = 7.
- Collision report:
  - Sequence: SOF; 100 cycles with one cycle layer_req = 8'b0000_0101; SOF.
  - Required: collision = 1 for exactly the cycle after the second SOF; goal_reached = 0.
  - A third SOF with no overlaps in between → no pulse.
- Goal plus hazard plus pre-first-SOF:
  - An overlap of 8'b1000_0011 before the first SOF → no report at the first SOF.
  - The same overlap between the first and second SOF → collision = goal_reached = 1 together after the second SOF.
- Overlap on the SOF cycle: layer_req = 8'b0000_0011 coincident with SOF only → not reported at that SOF; reported at the next SOF.
- Reset mid-frame:
  - Sequence: SOF, overlap, RESET for 1 cycle, SOF.
  - Required: no collision pulse, and frame_valid rises one cycle after that SOF.
